// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The cache controller uses the slave modport; the CPU/memory side uses master.
interface dcache_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_address;
  logic [7:0]  cpu_write_data;
  logic [7:0]  cpu_read_data;
  logic        cpu_busy_wait;
  logic        mem_read;
  logic        mem_write;
  logic [6:0]  mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_busy_wait;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_write_data,
           mem_read_data, mem_busy_wait,
    output cpu_read_data, cpu_busy_wait,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_write_data,
           mem_read_data, mem_busy_wait,
    input  cpu_read_data, cpu_busy_wait,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller:
// 8 lines of 2-byte blocks, 4-bit tags, single outstanding miss.
module dcache_ctrl (
  input  logic     clk,
  input  logic     rst,
  dcache_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t      state, next;
  logic [7:0]  valid, dirty;
  logic [3:0]  tag_arr [8];
  logic [15:0] data_arr [8];
  logic [15:0] fill;
  logic        armed;

  logic [2:0]  index;
  logic [3:0]  tag;
  logic        offset;
  logic        rd_only, wr_only, hit, wr_hit, mem_done;

  logic        busy_c, mem_read_c, mem_write_c;
  logic [6:0]  mem_address_c;
  logic [15:0] mem_write_data_c;
  logic [7:0]  read_data_c;

  assign index    = bus.cpu_address[3:1];
  assign tag      = bus.cpu_address[7:4];
  assign offset   = bus.cpu_address[0];
  assign rd_only  = bus.cpu_read & ~bus.cpu_write;
  assign wr_only  = bus.cpu_write & ~bus.cpu_read;
  assign hit      = valid[index] && (tag_arr[index] == tag);
  assign wr_hit   = (state == IDLE) && wr_only && hit;
  // armed is low on the first edge of a memory state, so busy is ignored there
  assign mem_done = armed && !bus.mem_busy_wait;

  always_comb begin
    next             = state;
    busy_c           = 1'b0;
    mem_read_c       = 1'b0;
    mem_write_c      = 1'b0;
    mem_address_c    = 7'd0;
    mem_write_data_c = 16'd0;
    read_data_c      = 8'd0;
    case (state)
      IDLE: begin
        if (rd_only || wr_only) begin
          if (!hit) begin
            busy_c = 1'b1;
            next   = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
          end else if (rd_only) begin
            read_data_c = offset ? data_arr[index][15:8] : data_arr[index][7:0];
          end
        end
      end
      WRITEBACK: begin
        busy_c           = 1'b1;
        mem_write_c      = 1'b1;
        mem_address_c    = {tag_arr[index], index};
        mem_write_data_c = data_arr[index];
        if (mem_done) next = ALLOCATE;
      end
      ALLOCATE: begin
        busy_c        = 1'b1;
        mem_read_c    = 1'b1;
        mem_address_c = {tag, index};
        if (mem_done) next = UPDATE;
      end
      UPDATE: begin
        busy_c = 1'b1;
        next   = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign bus.cpu_busy_wait  = busy_c;
  assign bus.cpu_read_data  = read_data_c;
  assign bus.mem_read       = mem_read_c;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_address    = mem_address_c;
  assign bus.mem_write_data = mem_write_data_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
      valid <= 8'd0;
      dirty <= 8'd0;
    end else begin
      state <= next;
      armed <= (state == next);
      if (state == UPDATE) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end else if (wr_hit) begin
        dirty[index] <= 1'b1;
      end
    end
  end

  // Line storage and refill buffer carry no reset; valid bits guard them
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && next == UPDATE)
      fill <= bus.mem_read_data;
    if (state == UPDATE) begin
      data_arr[index] <= fill;
      tag_arr[index]  <= tag;
    end else if (wr_hit) begin
      if (offset) data_arr[index][15:8] <= bus.cpu_write_data;
      else        data_arr[index][7:0]  <= bus.cpu_write_data;
    end
  end

endmodule
